hazard_scoreboard: RTL and testbench

Parametrised stall/forward controller for the 5-stage pipeline, successor to the per-instruction Tuse/Tnew decode. It takes the D-stage decoded hazard fields (source addresses, Tuse, destination, TnewD) and keeps an internal E/M/W producer scoreboard with saturating Tnew countdown. From that it produces the D-stage stall, the per-operand forward selects and the bubble-insert request. It also adds a multi-cycle MDU busy counter with configurable mult/div latency, which the combinational decoder cannot express.

---
 rtl/hazard_scoreboard.sv | 154 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Stall/forward controller for the 5-stage pipeline. It tracks the
//   producers sitting in E, M and W, each with a Tnew countdown that
//   saturates at 0. For each D-stage source operand it finds the nearest
//   producer and decides whether to stall or which stage to forward from.
//   A separate counter models multi-cycle MDU occupancy, so HI/LO users are
//   held until the mult/div result exists.
//
// Ports
//   clk                   pipeline clock, rising edge
//   reset                 asynchronous, active-high; clears slots and MDU counter
//   rs_d, rt_d            D-stage source register addresses
//   rs_used_d, rt_used_d  the source is actually read
//   tuse_rs_d, tuse_rt_d  cycles until D needs that operand
//   dst_d, we_d, tnew_d   D-stage destination, write enable and Tnew
//   mdu_op_d, mdu_div_d   D starts the MDU; div-class when mdu_div_d is set
//   mdu_use_d             D touches HI/LO or starts the MDU
//   stall                 hold F/D and push a bubble into E (combinational)
//   fwd_rs, fwd_rt        0 = RF, 1 = E, 2 = M, 3 = W (combinational)
//   mdu_busy              MDU counter non-zero
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          rs_used_d,
    input  logic          rt_used_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [AW-1:0] dst_d,
    input  logic          we_d,
    input  logic [TW-1:0] tnew_d,
    input  logic          mdu_op_d,
    input  logic          mdu_div_d,
    input  logic          mdu_use_d,
    output logic          stall,
    output logic [1:0]    fwd_rs,
    output logic [1:0]    fwd_rt,
    output logic          mdu_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [TW-1:0] tnew;
        logic          mdu;
        logic          div;
    } slot_t;

    slot_t         e_q, m_q, w_q;
    slot_t         e_d, m_d, w_d;
    logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;

    logic          stall_rs, stall_rt, stall_mdu;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic slot_t age_slot(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = sat_dec(s.tnew);
        return r;
    endfunction

    function automatic logic slot_match(input slot_t s, input logic [AW-1:0] src,
                                        input logic used);
        return s.we && (s.addr == src) && (src != '0) && used;
    endfunction

    // Nearest producer wins: a younger write hides any older one, even an
    // older one whose value is already available.
    function automatic void resolve(input slot_t e, input slot_t m, input slot_t w,
                                    input logic [AW-1:0] src, input logic used,
                                    input logic [TW-1:0] tuse,
                                    output logic stall_o, output logic [1:0] fwd_o);
        logic          hit;
        logic [TW-1:0] ptnew;
        logic [1:0]    pcode;
        hit   = 1'b0;
        ptnew = '0;
        pcode = 2'd0;
        if (slot_match(e, src, used)) begin
            hit = 1'b1; ptnew = e.tnew; pcode = 2'd1;
        end else if (slot_match(m, src, used)) begin
            hit = 1'b1; ptnew = m.tnew; pcode = 2'd2;
        end else if (slot_match(w, src, used)) begin
            hit = 1'b1; ptnew = w.tnew; pcode = 2'd3;
        end
        stall_o = hit && (ptnew > tuse);
        fwd_o   = (hit && (ptnew == '0)) ? pcode : 2'd0;
    endfunction

    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        fwd_rs   = 2'd0;
        fwd_rt   = 2'd0;
        resolve(e_q, m_q, w_q, rs_d, rs_used_d, tuse_rs_d, stall_rs, fwd_rs);
        resolve(e_q, m_q, w_q, rt_d, rt_used_d, tuse_rt_d, stall_rt, fwd_rt);
    end

    assign mdu_busy  = (mdu_cnt_q != '0);
    // An MDU op still in E has not loaded the counter yet, so it blocks too.
    assign stall_mdu = mdu_use_d && (mdu_busy || e_q.mdu);
    assign stall     = stall_rs || stall_rt || stall_mdu;

    always_comb begin
        m_d = age_slot(e_q);
        w_d = age_slot(m_q);
        e_d = '0;
        if (!stall) begin
            e_d.we   = we_d;
            e_d.addr = dst_d;
            e_d.tnew = sat_dec(tnew_d);
            e_d.mdu  = mdu_op_d;
            e_d.div  = mdu_op_d && mdu_div_d;
        end
    end

    // The counter loads from E regardless of stall; a concurrent bubble has
    // mdu = 0, so the op is counted exactly once.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (e_q.mdu) begin
            mdu_cnt_d = e_q.div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            mdu_cnt_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int TW = 2;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rs_d, rt_d, dst_d;
    logic          rs_used_d, rt_used_d, we_d;
    logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic          mdu_op_d, mdu_div_d, mdu_use_d;
    logic          stall, mdu_busy;
    logic [1:0]    fwd_rs, fwd_rt;

    int checks;
    int errors;

    hazard_scoreboard #(.AW(AW), .TW(TW), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .rs_used_d (rs_used_d),
        .rt_used_d (rt_used_d),
        .tuse_rs_d (tuse_rs_d),
        .tuse_rt_d (tuse_rt_d),
        .dst_d     (dst_d),
        .we_d      (we_d),
        .tnew_d    (tnew_d),
        .mdu_op_d  (mdu_op_d),
        .mdu_div_d (mdu_div_d),
        .mdu_use_d (mdu_use_d),
        .stall     (stall),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .mdu_busy  (mdu_busy)
    );

    // Clock/reset: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Driver tasks. Inputs change 1 ns after the rising edge; outputs are
    // sampled on the falling edge.
    task automatic clear_d();
        rs_d = '0; rt_d = '0; dst_d = '0;
        rs_used_d = 1'b0; rt_used_d = 1'b0; we_d = 1'b0;
        tuse_rs_d = '0; tuse_rt_d = '0; tnew_d = '0;
        mdu_op_d = 1'b0; mdu_div_d = 1'b0; mdu_use_d = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue_write(input logic [AW-1:0] dst, input logic [TW-1:0] tn);
        clear_d();
        we_d = 1'b1; dst_d = dst; tnew_d = tn;
    endtask

    task automatic flush();
        clear_d();
        repeat (4) next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_d();
        reset = 1'b1;

        // Reset state, with a D instruction that would otherwise look hazardous
        repeat (2) next_cycle();
        rs_d = 5'd3; rs_used_d = 1'b1; rt_d = 5'd3; rt_used_d = 1'b1;
        sample();
        check_eq("reset_stall", stall, 0);
        check_eq("reset_fwd_rs", fwd_rs, 0);
        check_eq("reset_fwd_rt", fwd_rt, 0);
        check_eq("reset_busy", mdu_busy, 0);
        #2 reset = 1'b0;
        next_cycle();

        // Asynchronous reset mid-stall
        issue_write(5'd8, 2'd3);
        sample();
        check_eq("rst_producer_stall", stall, 0);
        next_cycle();
        clear_d();
        rs_d = 5'd8; rs_used_d = 1'b1; tuse_rs_d = 2'd0;
        sample();
        check_eq("rst_pre_stall", stall, 1);
        check_eq("rst_pre_fwd", fwd_rs, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_stall", stall, 0);
        #1 reset = 1'b0;
        check_eq("rst_release_stall", stall, 0);
        check_eq("rst_release_fwd", fwd_rs, 0);
        next_cycle();
        sample();
        check_eq("rst_after_edge_stall", stall, 0);
        flush();

        // RR-cal back-to-back: tnew_d=2, user tuse=1
        issue_write(5'd9, 2'd2);
        next_cycle();
        clear_d();
        rs_d = 5'd9; rs_used_d = 1'b1; tuse_rs_d = 2'd1;
        sample();
        check_eq("rr_e_stall", stall, 0);
        check_eq("rr_e_fwd", fwd_rs, 0);
        next_cycle();
        sample();
        check_eq("rr_m_stall", stall, 0);
        check_eq("rr_m_fwd", fwd_rs, 2);
        flush();

        // Load-use: tnew_d=3, user tuse=0 on rt
        issue_write(5'd10, 2'd3);
        next_cycle();
        clear_d();
        rt_d = 5'd10; rt_used_d = 1'b1; tuse_rt_d = 2'd0;
        sample();
        check_eq("lu_c1_stall", stall, 1);
        check_eq("lu_c1_fwd", fwd_rt, 0);
        next_cycle();
        sample();
        check_eq("lu_c2_stall", stall, 1);
        check_eq("lu_c2_fwd", fwd_rt, 0);
        next_cycle();
        sample();
        check_eq("lu_c3_stall", stall, 0);
        check_eq("lu_c3_fwd", fwd_rt, 3);
        flush();

        // Nearest producer: W holds a ready write to 11, E a pending one
        issue_write(5'd11, 2'd0);
        next_cycle();
        clear_d();
        next_cycle();
        issue_write(5'd11, 2'd2);
        next_cycle();
        clear_d();
        rs_d = 5'd11; rs_used_d = 1'b1; tuse_rs_d = 2'd0;
        sample();
        check_eq("near_stall", stall, 1);
        check_eq("near_fwd", fwd_rs, 0);
        next_cycle();
        sample();
        check_eq("near_m_stall", stall, 0);
        check_eq("near_m_fwd", fwd_rs, 2);
        flush();

        // Writes to register 0 are invisible
        issue_write(5'd0, 2'd3);
        next_cycle();
        clear_d();
        rs_d = 5'd0; rs_used_d = 1'b1; rt_d = 5'd0; rt_used_d = 1'b1;
        sample();
        check_eq("zero_stall", stall, 0);
        check_eq("zero_fwd_rs", fwd_rs, 0);
        check_eq("zero_fwd_rt", fwd_rt, 0);
        flush();

        // Unused operand does not match
        issue_write(5'd13, 2'd3);
        next_cycle();
        clear_d();
        rs_d = 5'd13; rs_used_d = 1'b0;
        sample();
        check_eq("unused_stall", stall, 0);
        flush();

        // Div followed by mfhi: 11 stall cycles, released on the 12th
        clear_d();
        mdu_op_d = 1'b1; mdu_div_d = 1'b1; mdu_use_d = 1'b1;
        sample();
        check_eq("div_issue_stall", stall, 0);
        check_eq("div_issue_busy", mdu_busy, 0);
        next_cycle();
        clear_d();
        mdu_use_d = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            sample();
            check_eq($sformatf("div_c%0d_stall", i), stall, 1);
            check_eq($sformatf("div_c%0d_busy", i), mdu_busy, (i >= 2) ? 1 : 0);
            next_cycle();
        end
        sample();
        check_eq("div_release_stall", stall, 0);
        check_eq("div_release_busy", mdu_busy, 0);
        flush();

        // Mult followed by mfhi: 6 stall cycles, released on the 7th
        clear_d();
        mdu_op_d = 1'b1; mdu_div_d = 1'b0; mdu_use_d = 1'b1;
        sample();
        check_eq("mul_issue_stall", stall, 0);
        next_cycle();
        clear_d();
        mdu_use_d = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sample();
            check_eq($sformatf("mul_c%0d_stall", i), stall, 1);
            check_eq($sformatf("mul_c%0d_busy", i), mdu_busy, (i >= 2) ? 1 : 0);
            next_cycle();
        end
        sample();
        check_eq("mul_release_stall", stall, 0);
        check_eq("mul_release_busy", mdu_busy, 0);
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
